// File: rtl/conv_stream_pkg.sv
// conv_stream_pkg: shared state encoding, widths and result-length helper for the Memory Z streamer
package conv_stream_pkg;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 6;
    localparam int SIZE_W = 5;
    localparam int SIZE_XLEN = 5;

    typedef enum logic [1:0] {IDLE, STREAM, FIN} state_t;

    function automatic int calc_total(input int size_y, input int size_x);
        return (size_y == 0) ? 0 : size_y + size_x - 1;
    endfunction
endpackage

// File: rtl/conv_stream_skid_fifo.sv
// conv_stream_skid_fifo: 2-entry FIFO that absorbs Memory Z read latency under stream backpressure
module conv_stream_skid_fifo #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic [1:0]    count
);
    logic [DW-1:0] mem_q [2];
    logic [DW-1:0] mem_d [2];
    logic          wr_q, wr_d, rd_q, rd_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          do_push, do_pop;

    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        mem_d   = mem_q;
        if (do_push) mem_d[wr_q] = din;
        wr_d  = wr_q ^ do_push;
        rd_d  = rd_q ^ do_pop;
        cnt_d = cnt_q + 2'(do_push) - 2'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: '0};
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign dout  = mem_q[rd_q];
    assign full  = cnt_q == 2'd2;
    assign empty = cnt_q == 2'd0;
    assign count = cnt_q;
endmodule

// File: rtl/conv_result_streamer.sv
// conv_result_streamer: streams Memory Z results over valid/ready; CONV_STREAM_CHECKSUM_EN adds a running checksum port
module conv_result_streamer
    import conv_stream_pkg::*;
#(
    parameter int DATA_WIDTH_MEMZ = DATA_W,
    parameter int ADDR_WIDTH_MEMZ = ADDR_W,
    parameter int SIZE_WIDTH      = SIZE_W,
    parameter int SIZE_X          = SIZE_XLEN
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [SIZE_WIDTH-1:0]      sizeY,
    output logic [ADDR_WIDTH_MEMZ-1:0] memZ_addr,
    input  logic [DATA_WIDTH_MEMZ-1:0] dataZ_read,
    output logic [DATA_WIDTH_MEMZ-1:0] dout,
    output logic                       dout_valid,
    input  logic                       dout_ready,
    output logic                       dout_last,
    output logic                       busy,
    output logic                       done
`ifdef CONV_STREAM_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH_MEMZ-1:0] checksum
`endif
);
    localparam int AW = ADDR_WIDTH_MEMZ;

    state_t        state_q, state_d;
    logic [AW-1:0] total_q, total_d, rd_cnt_q, rd_cnt_d, tx_cnt_q, tx_cnt_d, addr_q, addr_d;
    logic          inflight_q, inflight_d;
    logic          accept, issue, pop, last_xfer, full, empty, at_last;
    logic [1:0]    count;
    logic [2:0]    occ;

    conv_stream_skid_fifo #(.DW(DATA_WIDTH_MEMZ)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight_q),
        .pop   (pop),
        .din   (dataZ_read),
        .dout  (dout),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = (sizeY == '0) ? FIN : STREAM;
            STREAM:  if (last_xfer) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy       = state_q == STREAM;
        done       = state_q == FIN;
        dout_valid = busy && !empty;
        at_last    = tx_cnt_q == total_q - AW'(1);
        dout_last  = dout_valid && at_last;
        pop        = dout_valid && dout_ready;
        last_xfer  = pop && at_last;
        // a word leaving this cycle frees a slot, keeping 1 word/cycle without exceeding 2 outstanding
        occ        = {1'b0, count} + {2'b0, inflight_q} - {2'b0, pop};
        issue      = busy && rd_cnt_q < total_q && occ < 3'd2 && !full;
        memZ_addr  = issue ? rd_cnt_q : addr_q;
    end

    always_comb begin
        accept     = state_q == IDLE && start;
        total_d    = accept ? AW'(calc_total(int'(sizeY), SIZE_X)) : total_q;
        rd_cnt_d   = accept ? '0 : rd_cnt_q + AW'(issue);
        tx_cnt_d   = accept ? '0 : tx_cnt_q + AW'(pop);
        addr_d     = memZ_addr;
        inflight_d = issue;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            total_q    <= '0;
            rd_cnt_q   <= '0;
            tx_cnt_q   <= '0;
            addr_q     <= '0;
            inflight_q <= 1'b0;
        end else begin
            total_q    <= total_d;
            rd_cnt_q   <= rd_cnt_d;
            tx_cnt_q   <= tx_cnt_d;
            addr_q     <= addr_d;
            inflight_q <= inflight_d;
        end
    end

`ifdef CONV_STREAM_CHECKSUM_EN
    logic [DATA_WIDTH_MEMZ-1:0] checksum_q, checksum_d;

    always_comb checksum_d = accept ? '0 : pop ? checksum_q + dout : checksum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) checksum_q <= '0;
        else     checksum_q <= checksum_d;
    end

    assign checksum = checksum_q;
`endif
endmodule

// File: tb/tb_conv_result_streamer.sv
// tb_conv_result_streamer: scoreboard bench for conv_result_streamer with a 1-cycle Memory Z model
module tb_conv_result_streamer;
    logic        clk = 0, rst = 1, start = 0, dout_ready = 1;
    logic [4:0]  sizeY = 0;
    logic [5:0]  memZ_addr;
    logic [15:0] dataZ_read = 0, dout;
    logic        dout_valid, dout_last, busy, done;
`ifdef CONV_STREAM_CHECKSUM_EN
    logic [15:0] checksum;
`endif
    logic [15:0] mem [64];
    logic [16:0] q [$];
    logic [16:0] exp_w;
    int          checks = 0, errors = 0;
    bit          bp = 0;

    conv_result_streamer u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .sizeY      (sizeY),
        .memZ_addr  (memZ_addr),
        .dataZ_read (dataZ_read),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last),
        .busy       (busy),
        .done       (done)
`ifdef CONV_STREAM_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) dataZ_read <= mem[memZ_addr];

    initial forever begin
        @(posedge clk);
        #1;
        dout_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task kick(input int sy);
        int total;
        total = (sy == 0) ? 0 : sy + 4;
        @(posedge clk);
        #1;
        start = 1;
        sizeY = 5'(sy);
        for (int i = 0; i < total; i++) q.push_back({i == total - 1, mem[i]});
        @(posedge clk);
        #1;
        start = 0;
    endtask

    task test_reset;
        #12;
        checks++;
        if ({memZ_addr, dout, dout_valid, dout_last, busy, done} !== 26'd0) begin
            errors++;
            $display("FAIL reset_state: addr=%0d dout=%0d v=%b l=%b busy=%b done=%b, want all 0",
                     memZ_addr, dout, dout_valid, dout_last, busy, done);
        end
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    task test_basic;
        int cyc, first, gaps;
        bit got_last, fin;
        cyc = 0; first = -1; gaps = 0; got_last = 0; fin = 0; bp = 0;
        kick(10);
        while (!fin && cyc < 100) begin
            @(negedge clk);
            if (got_last) begin
                checks++;
                if (done !== 1'b1 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_done: done=%b busy=%b, want 1/0", done, busy);
                end
`ifdef CONV_STREAM_CHECKSUM_EN
                checks++;
                if (checksum !== 16'h05D3) begin
                    errors++;
                    $display("FAIL basic_checksum: got %h, want 05d3", checksum);
                end
`endif
                fin = 1;
            end else begin
                if (dout_valid && first < 0) first = cyc;
                if (first >= 0 && !dout_valid) gaps++;
                checks++;
                if (done !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_early_done: done=%b at cycle %0d, want 0", done, cyc);
                end
                if (dout_valid && dout_ready) begin
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL basic_extra: word %0d with empty scoreboard", dout);
                    end else begin
                        exp_w = q.pop_front();
                        if ({dout_last, dout} !== exp_w) begin
                            errors++;
                            $display("FAIL basic_word: got last=%b d=%0d, want last=%b d=%0d",
                                     dout_last, dout, exp_w[16], exp_w[15:0]);
                        end
                        got_last = q.size() == 0;
                    end
                end
            end
            cyc++;
        end
        checks++;
        if (!fin) begin errors++; $display("FAIL basic_timeout: %0d words left, want 0", q.size()); end
        checks++;
        if (first != 2) begin errors++; $display("FAIL basic_latency: first valid at %0d, want 2", first); end
        checks++;
        if (gaps != 0) begin errors++; $display("FAIL basic_gaps: %0d bubbles, want 0", gaps); end
        q.delete();
    endtask

    task test_backpressure;
        int cyc, outst;
        bit pv, pr, pl;
        logic [15:0] pd;
        cyc = 0; pv = 0; pr = 1; pl = 0; pd = 0; bp = 1;
        kick(10);
        while (q.size() != 0 && cyc < 300) begin
            @(negedge clk);
            if (pv && !pr) begin
                checks++;
                if (!dout_valid || dout !== pd || dout_last !== pl) begin
                    errors++;
                    $display("FAIL bp_stable: v=%b d=%0d l=%b, want v=1 d=%0d l=%b", dout_valid, dout, dout_last, pd, pl);
                end
            end
            outst = int'(u_dut.u_fifo.count) + int'(u_dut.inflight_q);
            checks++;
            if (outst > 2) begin errors++; $display("FAIL bp_outstanding: %0d, want <=2", outst); end
            if (dout_valid && dout_ready) begin
                checks++;
                exp_w = q.pop_front();
                if ({dout_last, dout} !== exp_w) begin
                    errors++;
                    $display("FAIL bp_word: got last=%b d=%0d, want last=%b d=%0d", dout_last, dout, exp_w[16], exp_w[15:0]);
                end
            end
            pv = dout_valid; pr = dout_ready; pd = dout; pl = dout_last;
            cyc++;
        end
        checks++;
        if (q.size() != 0) begin errors++; $display("FAIL bp_timeout: %0d words left, want 0", q.size()); end
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL bp_done: done=%b, want 1", done); end
        bp = 0;
        q.delete();
    endtask

    task test_zero;
        kick(0);
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || dout_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_done: done=%b v=%b busy=%b, want 1/0/0", done, dout_valid, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_pulse: done=%b v=%b, want 0/0", done, dout_valid);
        end
    endtask

    task test_max;
        int cyc, n;
        cyc = 0; n = 0;
        kick(31);
        while (q.size() != 0 && cyc < 200) begin
            @(negedge clk);
            if (dout_valid && dout_ready) begin
                checks++;
                exp_w = q.pop_front();
                n++;
                if ({dout_last, dout} !== exp_w) begin
                    errors++;
                    $display("FAIL max_word: got last=%b d=%0d, want last=%b d=%0d", dout_last, dout, exp_w[16], exp_w[15:0]);
                end
            end
            cyc++;
        end
        checks++;
        if (n != 35) begin errors++; $display("FAIL max_count: %0d words, want 35", n); end
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL max_done: done=%b, want 1", done); end
        q.delete();
    endtask

    task test_start_busy;
        int cyc, n;
        cyc = 0; n = 0;
        kick(10);
        while (q.size() != 0 && cyc < 100) begin
            @(negedge clk);
            if (cyc == 5) begin start = 1; sizeY = 3; end
            if (cyc == 9) start = 0;
            if (dout_valid && dout_ready) begin
                checks++;
                exp_w = q.pop_front();
                n++;
                if ({dout_last, dout} !== exp_w) begin
                    errors++;
                    $display("FAIL busy_word: got last=%b d=%0d, want last=%b d=%0d", dout_last, dout, exp_w[16], exp_w[15:0]);
                end
            end
            cyc++;
        end
        checks++;
        if (n != 14) begin errors++; $display("FAIL busy_count: %0d words, want 14", n); end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL busy_restart: busy=%b v=%b, want 0/0", busy, dout_valid);
        end
        q.delete();
    endtask

    task test_reset_mid;
        int cyc, n;
        cyc = 0; n = 0;
        kick(10);
        while (n < 5 && cyc < 100) begin
            @(negedge clk);
            if (dout_valid && dout_ready) n++;
            cyc++;
        end
        #2;
        rst = 1;
        #1;
        checks++;
        if ({memZ_addr, dout, dout_valid, dout_last, busy, done} !== 26'd0) begin
            errors++;
            $display("FAIL rst_mid: addr=%0d dout=%0d v=%b l=%b busy=%b done=%b, want all 0",
                     memZ_addr, dout, dout_valid, dout_last, busy, done);
        end
        q.delete();
        @(posedge clk);
        #1;
        rst = 0;
        test_basic();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'(i + 100);
        test_reset();
        test_basic();
        test_backpressure();
        test_zero();
        test_max();
        test_start_busy();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv_result_streamer.md
Name: conv_result_streamer

Overview:
- Downstream stage of the 1D convolution coprocessor core.
- After the core finishes, it reads convolution results out of Memory Z (16-bit words, 6-bit address, synchronous RAM with 1-cycle read latency).
- It presents the results, in order, on a valid/ready output stream with a last-word marker.
- It hides RAM read latency with a 2-entry skid buffer, so it sustains 1 word/cycle under no backpressure.

Parameters:
- DATA_WIDTH_MEMZ, 16, Memory Z word width and stream data width.
- ADDR_WIDTH_MEMZ, 6, Memory Z address width.
- SIZE_WIDTH, 5, width of sizeY.
- SIZE_X, 5, fixed kernel length of the core; result count = sizeY + SIZE_X - 1.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  level or pulse; sampled in IDLE only (typically the core's done).
- sizeY  in  SIZE_WIDTH  input length; sampled on accepted start.
- memZ_addr  out  ADDR_WIDTH_MEMZ  Memory Z read address.
- dataZ_read  in  DATA_WIDTH_MEMZ  Memory Z read data, valid 1 cycle after address.
- dout  out  DATA_WIDTH_MEMZ  stream data.
- dout_valid  out  1  stream valid.
- dout_ready  in  1  stream ready; transfer when valid && ready.
- dout_last  out  1  high with the final word.
- busy  out  1  high while a readout is in progress.
- done  out  1  one-cycle pulse after the final transfer.

Behaviour:
- Reset values:
  - memZ_addr=0, dout=0, dout_valid=0, dout_last=0, busy=0, done=0.
  - Buffer empty, in-flight flag clear, state IDLE.
- Length rule:
  - total = sizeY + SIZE_X - 1, computed in ADDR_WIDTH_MEMZ bits (max 35, no overflow).
  - sizeY=0 gives total=0.
- States:
  - IDLE:
    - start=1 and sizeY!=0 → latch total, rd_cnt=0, tx_cnt=0, go to STREAM, busy=1 next cycle.
    - start=1 and sizeY=0 → go to FIN without any read.
  - STREAM:
    - A read is issued (memZ_addr=rd_cnt, rd_cnt++) when rd_cnt<total and buffer occupancy + in-flight < 2.
    - Returning data is written into the buffer the cycle after issue.
    - The buffer head drives dout/dout_valid.
    - dout_last = dout_valid && (tx_cnt == total-1).
    - Each handshake increments tx_cnt.
    - Handshake on the last word → FIN.
  - FIN: done=1 for one cycle, busy=0 in that cycle, then IDLE.
- Ordering and stability:
  - Words emerge in address order 0..total-1, with no loss or duplication under any dout_ready pattern.
  - dout and dout_last are held stable while dout_valid && !dout_ready.
- Throughput: with dout_ready held high, the first dout_valid appears 2 cycles after entering STREAM, then 1 word/cycle.
- Simultaneous events: buffer push and pop in the same cycle are both honoured, and occupancy is unchanged.
- start while busy or in FIN is ignored; no re-latch of sizeY.
- memZ_addr holds its last value when no read is issued.
- rst mid-operation:
  - Immediate return to reset values and IDLE.
  - Any in-flight read data is discarded.

Optional Feature:
- Macro: CONV_STREAM_CHECKSUM_EN.
- Defined:
  - Adds output port checksum (DATA_WIDTH_MEMZ), which is the modulo-2^16 sum of all transferred dout words.
  - Cleared on accepted start and on rst.
  - Final value is valid in the done cycle and held until the next accepted start.
- Undefined: the port and logic are absent; all other behaviour is identical.

Decomposition:
- Package conv_stream_pkg holds:
  - state enum (IDLE, STREAM, FIN);
  - width localparams;
  - a function computing total from sizeY and SIZE_X.
- Sub-module conv_stream_skid_fifo:
  - 2-entry, DATA_WIDTH_MEMZ wide FIFO;
  - push/pop/full/empty/count ports;
  - async active-high reset.

Test Plan:
- Basic readout:
  - Stimulus: Memory Z preloaded with addr+100, sizeY=10, start pulse, dout_ready=1.
  - Required: 14 words 100..113 consecutively, dout_last only on 113, done one cycle after the 113 handshake, busy low with done.
- Backpressure:
  - Stimulus: same preload, dout_ready random 50%.
  - Required: same 14-word sequence, dout stable while stalled, at most 2 outstanding reads (buffer + in-flight) at any time.
- Boundaries:
  - sizeY=0 → no dout_valid, done pulse 2 cycles after start.
  - sizeY=31 → 35 words, addr 0..34, last on addr 34.
- Start while busy:
  - Stimulus: start re-asserted mid-stream with sizeY=3.
  - Required: ignored, original 14-word run completes unchanged.
- Reset mid-stream:
  - Stimulus: rst asserted after the 5th transfer.
  - Required: all outputs 0 immediately; a new start then produces a full fresh sequence from addr 0.
- Checksum (CONV_STREAM_CHECKSUM_EN defined):
  - Stimulus: basic readout.
  - Required: checksum = sum(100..113) = 1491 = 16'h05D3 in the done cycle.
